// File: rtl/match_event_counter_pkg.sv
// match_evt_pkg: shared types and default sizing for match_event_counter.
package match_evt_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int WIN_LEN_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/match_event_counter_if.sv
// match_event_counter_if: report channel (valid/ready plus payload).
// master = counter side driving the report, slave = consumer side.
import match_evt_pkg::*;

interface match_event_counter_if #(
  parameter int CNT_W = CNT_W_DEF
);
  logic             rep_valid;
  logic             rep_ready;
  logic [CNT_W-1:0] rep_count;
  logic             rep_sat;
  logic             rep_partial;

  modport master (
    output rep_valid, rep_count, rep_sat, rep_partial,
    input  rep_ready
  );

  modport slave (
    input  rep_valid, rep_count, rep_sat, rep_partial,
    output rep_ready
  );
endinterface

// File: rtl/match_event_counter_rise_edge_det.sv
// rise_edge_det: registers the previous input level and flags 0->1 steps.
// The previous value is tracked every cycle regardless of the caller's state.
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev;

  // previous-cycle level, cleared by reset so a high first sample is an edge
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  assign rise = d & ~prev;
endmodule

// File: rtl/match_event_counter.sv
// match_event_counter: counts rising edges of det_in per WIN_LEN-cycle window
// and hands each window's count out on a registered valid/ready channel.
// Optional feature: define MATCH_EVT_DROP_CNT_EN to add the drop_cnt output,
// which counts reports discarded because the previous one was still pending.
import match_evt_pkg::*;

module match_event_counter #(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic det_in,
  input  logic en,
  match_event_counter_if.master rep
`ifdef MATCH_EVT_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int WIN_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] ACC_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] acc;
  logic [WIN_W-1:0] win;
  logic             sat;
  logic             evt;

  logic [CNT_W-1:0] acc_add;
  logic             sat_add;
  logic             rpt_fire;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_sat;
  logic             rpt_partial;
  logic             rpt_hold;

  rise_edge_det u_det (
    .clk  (clk),
    .rst  (rst),
    .d    (det_in),
    .rise (evt)
  );

  // accumulator next value: saturate at all-ones and latch the overflow flag
  always_comb begin
    acc_add = acc;
    sat_add = sat;
    if (evt) begin
      if (acc == ACC_MAX) sat_add = 1'b1;
      else                acc_add = acc + 1'b1;
    end
  end

  // report request: full window closes in RUN, partial one drains in FLUSH
  always_comb begin
    rpt_fire    = 1'b0;
    rpt_count   = acc_add;
    rpt_sat     = sat_add;
    rpt_partial = 1'b0;
    case (state)
      S_RUN: begin
        if (en && (win == WIN_LAST)) rpt_fire = 1'b1;
      end
      S_FLUSH: begin
        rpt_count   = acc;
        rpt_sat     = sat;
        rpt_partial = 1'b1;
        // an empty window that never advanced has nothing to report
        rpt_fire    = (win != '0) || (acc != '0);
      end
      default: ;
    endcase
  end

  // a pending, unaccepted report blocks any new one on this edge
  assign rpt_hold = rep.rep_valid & ~rep.rep_ready;

  // window FSM: accumulator, window counter and saturation flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      win   <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          acc <= '0;
          win <= '0;
          sat <= 1'b0;
          if (en) state <= S_RUN;
        end
        S_RUN: begin
          if (!en) begin
            // this cycle's event is dropped; window state kept for the flush
            state <= S_FLUSH;
          end else if (win == WIN_LAST) begin
            // window closes, next cycle is window cycle 0 with no gap
            acc <= '0;
            win <= '0;
            sat <= 1'b0;
          end else begin
            acc <= acc_add;
            sat <= sat_add;
            win <= win + 1'b1;
          end
        end
        S_FLUSH: begin
          acc   <= '0;
          win   <= '0;
          sat   <= 1'b0;
          state <= en ? S_RUN : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // report register: load when free or being accepted, drop when blocked
  always_ff @(posedge clk) begin
    if (rst) begin
      rep.rep_valid   <= 1'b0;
      rep.rep_count   <= '0;
      rep.rep_sat     <= 1'b0;
      rep.rep_partial <= 1'b0;
    end else if (rpt_fire && !rpt_hold) begin
      rep.rep_valid   <= 1'b1;
      rep.rep_count   <= rpt_count;
      rep.rep_sat     <= rpt_sat;
      rep.rep_partial <= rpt_partial;
    end else if (rep.rep_valid && rep.rep_ready) begin
      rep.rep_valid   <= 1'b0;
    end
  end

`ifdef MATCH_EVT_DROP_CNT_EN
  // count discarded reports, sticking at 255
  always_ff @(posedge clk) begin
    if (rst)                                      drop_cnt <= 8'd0;
    else if (rpt_fire && rpt_hold && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule
